// File: rtl/demux_deser8_pkg.sv
// -----------------------------------------------------------------------------
// demux_deser8_pkg
// Shared constants for the serial-to-parallel deserializer.
//   DESER_WIDTH      : default word width (power of 2, >= 2)
//   DESER_SEL_W      : default slot counter width, log2(DESER_WIDTH)
//   DESER_SLOT_FIRST : slot that a new word starts in
//   deser_last_slot(): slot index holding the word's MSB for a given width
// -----------------------------------------------------------------------------
`ifndef DEMUX_DESER8_PKG_SV
`define DEMUX_DESER8_PKG_SV

package demux_deser8_pkg;

    localparam int DESER_WIDTH      = 8;
    localparam int DESER_SEL_W      = 3;
    localparam int DESER_SLOT_FIRST = 0;

    // Last slot of a word; the bit landing here completes the word.
    function automatic int deser_last_slot(input int width);
        return width - 1;
    endfunction

endpackage

`endif

// File: rtl/demux_slot_dec.sv
// -----------------------------------------------------------------------------
// demux_slot_dec
// 1-to-WIDTH demux tree producing one-hot write enables for the assembly
// register. The tree mirrors the transmit-side bit-select mux tree: the root
// is the enable, each level splits on one select bit, MSB at the root.
//
// Ports:
//   en   in   1      gate; all enables are 0 when low
//   sel  in   SEL_W  slot to enable
//   we   out  WIDTH  one-hot (or zero) per-bit write enables
// -----------------------------------------------------------------------------
module demux_slot_dec #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] we
);

    // Level gi consumes select bit SEL_W-1-gi and doubles the node count.
    // Node gp at a level feeds children 2*gp (bit=0) and 2*gp+1 (bit=1), so
    // the leaf position equals the binary value of sel.
    genvar gi, gp;
    generate
        for (gi = 0; gi < SEL_W; gi++) begin : g_lvl
            logic [(1 << gi)-1:0] parent;
            logic [(2 << gi)-1:0] node;

            if (gi == 0) begin : g_root
                assign parent = en;
            end else begin : g_inner
                assign parent = g_lvl[gi-1].node;
            end

            for (gp = 0; gp < (1 << gi); gp++) begin : g_split
                assign node[2*gp]   = parent[gp] & ~sel[SEL_W-1-gi];
                assign node[2*gp+1] = parent[gp] &  sel[SEL_W-1-gi];
            end
        end
    endgenerate

    assign we = g_lvl[SEL_W-1].node;

endmodule

// File: rtl/demux_deser8.sv
// -----------------------------------------------------------------------------
// demux_deser8
// Serial-to-parallel deserializer. Each accepted serial bit (LSB first) is
// steered by a slot counter through a demux into the assembly register; the
// bit in the last slot completes the word, which is copied into an output
// holding register and offered on a valid/ready interface.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   ser_in     in   1      serial data bit
//   ser_valid  in   1      ser_in valid this cycle
//   ser_start  in   1      bit is slot 0 of a new word (qualified by ser_valid)
//   ser_ready  out  1      bit can be accepted this cycle (combinational)
//   par_data   out  WIDTH  assembled word
//   par_valid  out  1      par_data valid
//   par_ready  in   1      consumer takes par_data
//   frame_err  out  1      sticky: ser_start arrived mid-word
//   err_clr    in   1      synchronous clear of frame_err (a new error wins)
//   slot       out  SEL_W  current slot counter (debug)
//
// WIDTH must be a power of 2 (>= 2) and SEL_W must equal log2(WIDTH); the
// slot counter relies on natural binary wrap from WIDTH-1 to 0.
// -----------------------------------------------------------------------------
module demux_deser8
    import demux_deser8_pkg::*;
#(
    parameter int WIDTH = DESER_WIDTH,
    parameter int SEL_W = DESER_SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             ser_start,
    output logic             ser_ready,
    output logic [WIDTH-1:0] par_data,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             frame_err,
    input  logic             err_clr,
    output logic [SEL_W-1:0] slot
);

    localparam logic [SEL_W-1:0] SLOT_FIRST = SEL_W'(DESER_SLOT_FIRST);
    localparam logic [SEL_W-1:0] SLOT_NEXT  = SEL_W'(DESER_SLOT_FIRST + 1);
    localparam logic [SEL_W-1:0] SLOT_LAST  = SEL_W'(deser_last_slot(WIDTH));

    // State
    logic [SEL_W-1:0] slot_reg,      slot_next;
    logic [WIDTH-1:0] asm_reg,       asm_next;
    logic [WIDTH-1:0] par_data_reg,  par_data_next;
    logic             par_valid_reg, par_valid_next;
    logic             frame_err_reg, frame_err_next;

    // Control
    logic             at_last;
    logic             accept;
    logic             complete;
    logic             start_err;
    logic [SEL_W-1:0] wr_slot;
    logic [WIDTH-1:0] bit_we;

    assign at_last = (slot_reg == SLOT_LAST);

    // Only the completing bit can stall: it needs the holding register free
    // (or being drained this same cycle). This is a deliberate combinational
    // path from par_ready to ser_ready.
    assign ser_ready = ~(par_valid_reg & ~par_ready & at_last);
    assign accept    = ser_valid & ser_ready;

    // ser_start forces the write into slot 0 whatever the counter says, so a
    // start bit can never be a completing bit.
    assign wr_slot   = ser_start ? SLOT_FIRST : slot_reg;
    assign complete  = accept & ~ser_start & at_last;
    assign start_err = accept & ser_start & (slot_reg != SLOT_FIRST);

    demux_slot_dec #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_slot_dec (
        .en  (accept),
        .sel (wr_slot),
        .we  (bit_we)
    );

    // Demux write: only the enabled slot takes ser_in, the rest hold. Bits
    // left over from an aborted word stay stale until rewritten.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_asm
            assign asm_next[gi] = bit_we[gi] ? ser_in : asm_reg[gi];
        end
    endgenerate

    always_comb begin
        slot_next = slot_reg;
        if (accept) begin
            slot_next = ser_start ? SLOT_NEXT : slot_reg + SEL_W'(1);
        end
    end

    // The completing bit is taken straight from ser_in so the word is
    // visible in par_data at the same edge as the last bit.
    always_comb begin
        par_data_next  = par_data_reg;
        par_valid_next = par_valid_reg;
        if (complete) begin
            par_data_next  = {ser_in, asm_reg[WIDTH-2:0]};
            par_valid_next = 1'b1;
        end else if (par_valid_reg && par_ready) begin
            par_valid_next = 1'b0;
        end
    end

    // A new error takes priority over a simultaneous clear.
    always_comb begin
        frame_err_next = frame_err_reg;
        if (start_err) begin
            frame_err_next = 1'b1;
        end else if (err_clr) begin
            frame_err_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_reg      <= '0;
            asm_reg       <= '0;
            par_data_reg  <= '0;
            par_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            slot_reg      <= slot_next;
            asm_reg       <= asm_next;
            par_data_reg  <= par_data_next;
            par_valid_reg <= par_valid_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign slot      = slot_reg;
    assign par_data  = par_data_reg;
    assign par_valid = par_valid_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_demux_deser8.sv
// -----------------------------------------------------------------------------
// tb_demux_deser8
// Self-checking bench for demux_deser8. Expected words are queued when their
// bits are driven and popped by a monitor whenever a word is handed over
// (par_valid & par_ready). Inputs change 1 ns after the rising edge; the
// monitor samples on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_demux_deser8;

    localparam int W = 8;
    localparam int S = 3;

    logic         clk;
    logic         rst_n;
    logic         ser_in;
    logic         ser_valid;
    logic         ser_start;
    logic         ser_ready;
    logic [W-1:0] par_data;
    logic         par_valid;
    logic         par_ready;
    logic         frame_err;
    logic         err_clr;
    logic [S-1:0] slot;

    demux_deser8 #(.WIDTH(W), .SEL_W(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .ser_start (ser_start),
        .ser_ready (ser_ready),
        .par_data  (par_data),
        .par_valid (par_valid),
        .par_ready (par_ready),
        .frame_err (frame_err),
        .err_clr   (err_clr),
        .slot      (slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [W-1:0] exp_q[$];
    int           pop_cyc[$];
    logic [W-1:0] mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Scoreboard monitor: a handover is seen before the edge that completes it.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && par_valid === 1'b1 && par_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL word_unexpected: got %0h, expected none (t=%0t)", par_data, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("word_out", 32'(par_data), 32'(mon_exp));
            end
            pop_cyc.push_back(cyc);
        end
    end

    // Drive one bit and hold it until accepted (bounded).
    task automatic send_bit(input logic b, input logic st, output int stalls);
        ser_valid = 1'b1;
        ser_in    = b;
        ser_start = st;
        stalls    = 0;
        while (ser_ready !== 1'b1 && stalls < 50) begin
            @(posedge clk);
            #1;
            stalls++;
        end
        if (ser_ready !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL ser_ready_timeout: got %0b, expected 1 (t=%0t)", ser_ready, $time);
        end
        @(posedge clk);
        #1;
        ser_start = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] word, input logic st, output int stalls);
        int s;
        stalls = 0;
        for (int i = 0; i < W; i++) begin
            send_bit(word[i], st && (i == 0), s);
            stalls += s;
        end
    endtask

    task automatic idle(input int n);
        ser_valid = 1'b0;
        ser_start = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic         start;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;

        vecs[0] = '{data: 8'hA5, start: 1'b0, exp: 8'hA5};
        vecs[1] = '{data: 8'h3C, start: 1'b0, exp: 8'h3C};
        vecs[2] = '{data: 8'h00, start: 1'b1, exp: 8'h00};
        vecs[3] = '{data: 8'hFF, start: 1'b0, exp: 8'hFF};
        vecs[4] = '{data: 8'h96, start: 1'b1, exp: 8'h96};
        vecs[5] = '{data: 8'h00, start: 1'b0, exp: 8'h00};
        vecs[5].data = 8'($urandom_range(0, 255));
        vecs[5].exp  = vecs[5].data;

        rst_n     = 1'b0;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        ser_start = 1'b0;
        par_ready = 1'b1;
        err_clr   = 1'b0;

        // ---------------- reset state ----------------
        #22;
        check("rst_slot",      32'(slot),      32'd0);
        check("rst_par_valid", 32'(par_valid), 32'd0);
        check("rst_par_data",  32'(par_data),  32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_ser_ready", 32'(ser_ready), 32'd1);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- single word 8'h4D, one-cycle pulse ----------------
        exp_q.push_back(8'h4D);
        send_word(8'h4D, 1'b0, st);
        ser_valid = 1'b0;
        check("w1_par_valid", 32'(par_valid), 32'd1);
        check("w1_par_data",  32'(par_data),  32'h4D);
        check("w1_slot",      32'(slot),      32'd0);
        @(posedge clk);
        #1;
        check("w1_pulse_end", 32'(par_valid), 32'd0);

        // ---------------- table: back-to-back words ----------------
        pop_cyc.delete();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].exp);
            send_word(vecs[i].data, vecs[i].start, st);
            check($sformatf("tbl%0d_stalls", i), 32'(st), 32'd0);
        end
        idle(2);
        check("tbl_pulses", 32'(pop_cyc.size()), 32'd6);
        for (int i = 1; i < pop_cyc.size(); i++) begin
            check($sformatf("tbl_spacing%0d", i), 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd8);
        end
        check("tbl_start_at_slot0_no_err", 32'(frame_err), 32'd0);

        // ---------------- backpressure ----------------
        par_ready = 1'b0;
        exp_q.push_back(8'hFF);
        send_word(8'hFF, 1'b0, st);
        exp_q.push_back(8'h01);
        for (int i = 0; i < W-1; i++) begin
            send_bit((i == 0) ? 1'b1 : 1'b0, 1'b0, st);
            check($sformatf("bp_bit%0d_stalls", i), 32'(st), 32'd0);
        end
        ser_valid = 1'b1;
        ser_in    = 1'b0;
        #1;
        check("bp_ready_drop", 32'(ser_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_data",  32'(par_data),  32'hFF);
        check("bp_hold_valid", 32'(par_valid), 32'd1);
        check("bp_hold_slot",  32'(slot),      32'd7);
        par_ready = 1'b1;
        #1;
        check("bp_ready_back", 32'(ser_ready), 32'd1);
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
        check("bp_reload_valid", 32'(par_valid), 32'd1);
        check("bp_reload_data",  32'(par_data),  32'h01);
        idle(2);
        check("bp_drained", 32'(par_valid), 32'd0);

        // ---------------- frame error ----------------
        for (int i = 0; i < 3; i++) send_bit(1'b1, (i == 0), st);
        exp_q.push_back(8'h01);
        send_word(8'h01, 1'b1, st);
        ser_valid = 1'b0;
        check("fe_set",  32'(frame_err), 32'd1);
        check("fe_data", 32'(par_data),  32'h01);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("fe_clr", 32'(frame_err), 32'd0);

        // ---------------- clear and new error in the same cycle ----------------
        send_bit(1'b0, 1'b0, st);
        send_bit(1'b1, 1'b0, st);
        err_clr = 1'b1;
        send_bit(1'b1, 1'b1, st);
        err_clr = 1'b0;
        check("fe_set_wins", 32'(frame_err), 32'd1);
        exp_q.push_back(8'hC3);
        for (int i = 1; i < W; i++) begin
            logic [W-1:0] w;
            w = 8'hC3;
            send_bit(w[i], 1'b0, st);
        end
        ser_valid = 1'b0;
        check("fe_word_after", 32'(par_data), 32'hC3);
        idle(2);

        // ---------------- async reset mid-word with par_valid=1 ----------------
        par_ready = 1'b0;
        send_word(8'h5A, 1'b0, st);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, st);
        ser_valid = 1'b0;
        check("ar_pre_slot",  32'(slot),      32'd5);
        check("ar_pre_valid", 32'(par_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_slot",      32'(slot),      32'd0);
        check("ar_par_valid", 32'(par_valid), 32'd0);
        check("ar_par_data",  32'(par_data),  32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        par_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ar_ser_ready", 32'(ser_ready), 32'd1);
        check("ar_frame_err", 32'(frame_err), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux_deser8.md
Name: demux_deser8

Overview:
- Serial-to-parallel deserializer. It is the receive-side counterpart of the datapath's bit-select mux tree.
- A slot counter drives a 1-to-WIDTH demux. The demux steers each accepted serial bit into its slot of an assembly register.
- A completed word moves to an output holding register and is offered on a valid/ready interface.
- Sits between a serial link front-end and the parallel datapath.

Parameters:
- WIDTH, 8: word width in bits; must be a power of 2, minimum 2.
- SEL_W, 3: slot counter width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ser_in  input  1  serial data bit, LSB first.
- ser_valid  input  1  ser_in is valid this cycle.
- ser_start  input  1  qualified by ser_valid; marks the bit as slot 0 of a new word.
- ser_ready  output  1  block can accept a bit this cycle.
- par_data  output  WIDTH  assembled word.
- par_valid  output  1  par_data is valid.
- par_ready  input  1  consumer accepts par_data.
- frame_err  output  1  sticky: ser_start arrived mid-word.
- err_clr  input  1  synchronous clear of frame_err.
- slot  output  SEL_W  current slot counter; debug only.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low. All state updates on rising clk except the asynchronous reset.
- Reset values: slot=0, assembly register=0, par_data=0, par_valid=0, frame_err=0. ser_ready is combinational and reads 1 when out of reset.
- Bit accept = ser_valid & ser_ready.
- Demux write: on accept, asm[slot] <= ser_in; all other asm bits hold.
- Slot advance: on accept, slot <= slot+1, wrapping WIDTH-1 -> 0.
- Completion: an accept with slot==WIDTH-1 loads {ser_in, asm[WIDTH-2:0]} into par_data and sets par_valid at the same edge. Latency from the last-bit edge to par_valid visible is 0 cycles (registered output).
- Output handshake: par_valid & par_ready clears par_valid at the next edge, unless a new word completes at the same edge. In that case par_data reloads and par_valid stays 1.
- par_data is stable while par_valid=1 and par_ready=0.
- Backpressure: ser_ready = ~(par_valid & ~par_ready & slot==WIDTH-1).
  - Bits for slots 0..WIDTH-2 are always accepted.
  - Only the completing bit stalls.
  - This is a combinational path par_ready -> ser_ready; it is permitted and documented.
- ser_start handling:
  - On accept with ser_start=1, the bit is written to slot 0 and slot <= 1, regardless of the current slot.
  - If the current slot != 0, the partial word is discarded (asm bits not overwritten hold stale values; they are never emitted unless rewritten), and frame_err <= 1.
  - ser_start with slot==0 is legal and raises no error.
  - WIDTH==... no special case: a completing bit with ser_start=1 is impossible, because ser_start forces slot 0.
- ser_start while stalled (slot==WIDTH-1, ser_ready=0): not accepted; nothing changes.
- frame_err: err_clr=1 clears it. If err_clr and a new error coincide, set wins.
- ser_valid=0: no state change except the output handshake.
- Reset mid-word or with par_valid=1: all state returns to reset values immediately; the partial word and any unconsumed word are lost.

Decomposition:
- Shared package/header (guarded include): DESER_WIDTH=8 and DESER_SEL_W=3 defaults, plus slot-0 and last-slot constants.
- Sub-module demux_slot_dec: combinational SEL_W -> WIDTH one-hot decoder gated by accept. It produces the per-bit write enables, structured as a demux tree mirroring the mux tree.
- The top level holds the counter, assembly/output registers, handshake and error logic.

Test Plan:
- Reset then 8 accepts of bits 1,0,1,1,0,0,1,0 with par_ready=1 -> par_data=8'h4D and par_valid=1 for exactly one cycle; slot returns to 0.
- Back-to-back words 8'hA5 then 8'h3C with continuous ser_valid and par_ready=1 -> two pulses, 8 cycles apart, with no ser_ready drop.
- Hold par_ready=0 after the word 8'hFF, then send the next 8'h01:
  - ser_ready drops only at slot 7, and par_data stays 8'hFF.
  - Raise par_ready -> 8'hFF is consumed, 8'h01 loads in the same cycle, and par_valid stays 1.
- Send 3 bits, then ser_start with bit 1 followed by 7 zeros -> frame_err=1, output 8'h01. err_clr pulse -> frame_err=0.
- Assert rst_n=0 asynchronously at slot 5 with par_valid=1 -> slot=0, par_valid=0, par_data=0 before the next clk edge.
- err_clr and a new ser_start error in the same cycle -> frame_err remains 1.
